// File: rtl/div_ratio_sched.sv
// Run-time controller for a programmable integer clock divider; ratio changes and stops land
// only on period boundaries. Define DIV_SCHED_CLAMP_EN to clamp short ratios to MIN_DIV.
module div_ratio_sched #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 4,
  parameter int unsigned MIN_DIV     = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  output logic             cfg_ready_o,
  output logic             div_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cur_div_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(MIN_DIV);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] r_cur_div, w_cur_div_d;
  logic [CNT_W-1:0] r_pend_div, w_pend_div_d;
  logic             r_pend_vld, w_pend_vld_d;
  logic             r_div, r_tick, r_err;
  logic             w_div_d, w_tick_d;
  logic             w_xfer, w_bad, w_cfg_ok, w_boundary;
  logic [CNT_W-1:0] w_cfg_val;

  assign w_xfer     = cfg_valid_i & ~r_pend_vld;
  assign w_bad      = cfg_div_i < MinDiv;
  assign w_boundary = (r_state != StIdle) && (r_cnt == r_cur_div - CNT_W'(1));

`ifdef DIV_SCHED_CLAMP_EN
  assign w_cfg_val = w_bad ? MinDiv : cfg_div_i;
  assign w_cfg_ok  = 1'b1;
`else
  assign w_cfg_val = cfg_div_i;
  assign w_cfg_ok  = ~w_bad;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_cur_div  <= DefDiv;
      r_pend_div <= '0;
      r_pend_vld <= 1'b0;
      r_div      <= 1'b0;
      r_tick     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_cur_div  <= w_cur_div_d;
      r_pend_div <= w_pend_div_d;
      r_pend_vld <= w_pend_vld_d;
      r_div      <= w_div_d;
      r_tick     <= w_tick_d;
      r_err      <= w_xfer & w_bad;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_cur_div_d  = r_cur_div;
    w_pend_div_d = r_pend_div;
    w_pend_vld_d = r_pend_vld;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (w_xfer && w_cfg_ok) w_cur_div_d = w_cfg_val;
        if (en_i) w_state_d = StRun;
      end
      StRun, StStop: begin
        // Pending ratio is consumed before a same-cycle transfer could refill it.
        if (w_boundary) begin
          w_cnt_d = '0;
          if (r_pend_vld) begin
            w_cur_div_d  = r_pend_div;
            w_pend_vld_d = 1'b0;
          end
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
        if (en_i) w_state_d = StRun;
        else if ((r_state == StStop) && w_boundary) w_state_d = StIdle;
        else w_state_d = StStop;
        if (w_xfer && w_cfg_ok) begin
          w_pend_vld_d = 1'b1;
          w_pend_div_d = w_cfg_val;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    // Outputs are registered from next-state values so they are glitch-free.
    w_div_d     = (w_state_d != StIdle) && (w_cnt_d < (w_cur_div_d >> 1));
    w_tick_d    = (w_state_d != StIdle) && (w_cnt_d == '0);
    busy_o      = r_state != StIdle;
    cfg_ready_o = ~r_pend_vld;
    div_o       = r_div;
    tick_o      = r_tick;
    cur_div_o   = r_cur_div;
    err_o       = r_err;
  end

endmodule

// File: tb/tb_div_ratio_sched.sv
// Self-checking bench for div_ratio_sched: directed scenarios plus randomized traffic, all
// checked against a period-level reference model.
module tb_div_ratio_sched;
  localparam int unsigned CNT_W       = 26;
  localparam int unsigned DEFAULT_DIV = 4;
  localparam int unsigned MIN_DIV     = 2;

  logic             clk_i = 1'b0;
  logic             rst_i, en_i, cfg_valid_i;
  logic [CNT_W-1:0] cfg_div_i;
  logic             cfg_ready_o, div_o, tick_o, busy_o, err_o;
  logic [CNT_W-1:0] cur_div_o;

  div_ratio_sched #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV),
    .MIN_DIV    (MIN_DIV)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_div_i  (cfg_div_i),
    .cfg_ready_o(cfg_ready_o),
    .div_o      (div_o),
    .tick_o     (tick_o),
    .busy_o     (busy_o),
    .cur_div_o  (cur_div_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 idle, 1 running, 2 stopping; pos is the position within the period.
  int          m_mode;
  int          m_pos;
  int unsigned m_ratio;
  int unsigned pend_q[$];
  bit          m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit en, input bit v, input int unsigned d,
                                     input bit rst);
    bit          xfer, bad, ok, last;
    int unsigned val;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_ratio = DEFAULT_DIV; m_err = 0;
      pend_q.delete();
      return;
    end
    xfer = v && (pend_q.size() == 0);
    bad  = d < MIN_DIV;
    val  = d;
    ok   = !bad;
`ifdef DIV_SCHED_CLAMP_EN
    if (bad) val = MIN_DIV;
    ok = 1;
`endif
    m_err = xfer && bad;
    if (m_mode == 0) begin
      if (xfer && ok) m_ratio = val;
      if (en) begin m_mode = 1; m_pos = 0; end
    end else begin
      last = (m_pos == int'(m_ratio) - 1);
      if (last) begin
        m_pos = 0;
        if (pend_q.size() > 0) m_ratio = pend_q.pop_front();
      end else begin
        m_pos++;
      end
      if (en) m_mode = 1;
      else if (m_mode == 2 && last) m_mode = 0;
      else m_mode = 2;
      if (xfer && ok) pend_q.push_back(val);
    end
  endfunction

  task automatic compare_all();
    check_eq("div_o",   div_o,   (m_mode != 0 && m_pos < int'(m_ratio / 2)) ? 1 : 0);
    check_eq("tick_o",  tick_o,  (m_mode != 0 && m_pos == 0) ? 1 : 0);
    check_eq("busy_o",  busy_o,  (m_mode != 0) ? 1 : 0);
    check_eq("ready",   cfg_ready_o, (pend_q.size() == 0) ? 1 : 0);
    check_eq("cur_div", cur_div_o, m_ratio);
    check_eq("err_o",   err_o,   m_err ? 1 : 0);
  endtask

  // Drive at the falling edge, step the model on the rising edge, sample 1 time unit later.
  task automatic cycle(input bit en, input bit v, input int unsigned d, input bit rst);
    en_i = en; cfg_valid_i = v; cfg_div_i = CNT_W'(d); rst_i = rst;
    @(posedge clk_i);
    model_step(en, v, d, rst);
    #1;
    compare_all();
    @(negedge clk_i);
  endtask

  logic [7:0] pat;
  int         ticks;
  bit         r_en;

  initial begin
    en_i = 0; cfg_valid_i = 0; cfg_div_i = '0; rst_i = 1;
    @(negedge clk_i);

    // Reset then run at the default ratio: 1100 repeating.
    cycle(0, 0, 0, 1);
    check_eq("rst_ready", cfg_ready_o, 1);
    check_eq("rst_cur", cur_div_o, DEFAULT_DIV);
    pat = '0; ticks = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 0);
      pat = {pat[6:0], div_o};
      ticks += int'(tick_o);
    end
    check_eq("pat_n4", pat, 8'b1100_1100);
    check_eq("ticks_n4", ticks, 2);

    // Offer N=3 mid-period; it lands at the next boundary.
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 3, 0);
    check_eq("n3_ready_low", cfg_ready_o, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_eq("n3_cur", cur_div_o, 3);
    pat = {7'b0, div_o};
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0);
      pat = {pat[6:0], div_o};
    end
    check_eq("pat_n3", pat[5:0], 6'b100100);

    // Drop en in the first high cycle of N=6.
    cycle(0, 0, 0, 1);
    cycle(0, 1, 6, 0);
    cycle(1, 0, 0, 0);
    pat = {7'b0, div_o}; ticks = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, 0, 0);
      pat = {pat[6:0], div_o};
      ticks += int'(tick_o);
    end
    check_eq("pat_stop", pat, 8'b1110_0000);
    check_eq("stop_ticks", ticks, 0);
    check_eq("stop_busy", busy_o, 0);

    // Out-of-range ratio in IDLE.
    cycle(0, 0, 0, 1);
    cycle(0, 1, 1, 0);
    check_eq("err_pulse", err_o, 1);
    cycle(0, 0, 0, 0);
    check_eq("err_clear", err_o, 0);
`ifdef DIV_SCHED_CLAMP_EN
    check_eq("bad_cur", cur_div_o, MIN_DIV);
`else
    check_eq("bad_cur", cur_div_o, DEFAULT_DIV);
`endif

    // Reset while running at N=5 with a value pending.
    cycle(0, 0, 0, 1);
    cycle(0, 1, 5, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 7, 0);
    check_eq("pend_ready", cfg_ready_o, 0);
    cycle(1, 0, 0, 1);
    check_eq("rst_div", div_o, 0);
    check_eq("rst_cur2", cur_div_o, DEFAULT_DIV);
    check_eq("rst_ready2", cfg_ready_o, 1);

    // N=8 offered exactly in a boundary cycle applies one full period later.
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 10 && m_pos != int'(m_ratio) - 1; i++) cycle(1, 0, 0, 0);
    check_eq("found_bnd", m_pos, int'(m_ratio) - 1);
    cycle(1, 1, 8, 0);
    check_eq("bnd_cur_old", cur_div_o, DEFAULT_DIV);
    for (int i = 0; i < 4; i++) cycle(1, 1, 8, 0);
    check_eq("bnd_cur_new", cur_div_o, 8);

    // Randomized traffic.
    r_en = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r_en = ~r_en;
      cycle(r_en, $urandom_range(0, 3) == 0, $urandom_range(0, 9), $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
